// File: rtl/csr_arb_pkg.sv
// Shared types and widths for the CSR bus arbiter.
// Counter widths cover the full legal range of RESP_LATENCY (1..7) and STARVE_LIMIT (1..15).
package csr_arb_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int LAT_MAX    = 7;
    localparam int STARVE_MAX = 15;
    localparam int LAT_W      = $clog2(LAT_MAX + 1);
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/csr_arb_pick.sv
// Combinational winner selection between the pipeline port (0) and the host port (1).
// Port 1 wins when it is the only one pending, or when port 0 has used up the starvation budget.
module csr_arb_pick
    import csr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                r0_pend,
    input  logic                r1_pend,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                any_pend,
    output logic                winner
);

    always_comb begin
        any_pend = r0_pend | r1_pend;
        winner   = r1_pend && (!r0_pend || (starve_cnt == STARVE_W'(STARVE_LIMIT)));
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Two-port arbiter for the shared CSR peripheral bus: one-cycle strobe, response sampled
// RESP_LATENCY cycles later, returned to the granted requester with a one-cycle ack.
module csr_bus_arbiter
    import csr_arb_pkg::*;
#(
    parameter int RESP_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_valid,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_valid,
    output logic              csr_read,
    output logic              csr_write,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata,
    input  logic              csr_valid,
    output logic              busy,
    output logic              grant
);

    state_t              state_q,  state_d;
    logic                grant_q,  grant_d;
    logic                rd_q,     rd_d;
    logic                wr_q,     wr_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [LAT_W-1:0]    lat_q,    lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                valid_q,  valid_d;

    logic r0_pend, r1_pend, any_pend, winner;

    assign r0_pend = r0_read | r0_write;
    assign r1_pend = r1_read | r1_write;

    csr_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .r0_pend   (r0_pend),
        .r1_pend   (r1_pend),
        .starve_cnt(starve_q),
        .any_pend  (any_pend),
        .winner    (winner)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                // Only grants made while port 1 is actually waiting count toward starvation.
                if (!r1_pend || winner) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
                if (any_pend) begin
                    grant_d = winner;
                    rd_d    = winner ? r1_read  : r0_read;
                    wr_d    = winner ? r1_write : r0_write;
                    addr_d  = winner ? r1_addr  : r0_addr;
                    wdata_d = winner ? r1_wdata : r0_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_d   = LAT_W'(RESP_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The last WAIT cycle is cycle strobe+RESP_LATENCY, when the bus response is valid.
                if (lat_q == '0) begin
                    rdata_d = csr_valid ? csr_rdata : '0;
                    valid_d = csr_valid;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            starve_q <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
        end
    end

    assign csr_read  = (state_q == ST_ISSUE) && rd_q;
    assign csr_write = (state_q == ST_ISSUE) && wr_q;
    assign csr_addr  = addr_q;
    assign csr_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant     = grant_q;
    assign r0_ack    = (state_q == ST_RESP) && !grant_q;
    assign r1_ack    = (state_q == ST_RESP) && grant_q;
    assign r0_rdata  = rdata_q;
    assign r1_rdata  = rdata_q;
    assign r0_valid  = valid_q;
    assign r1_valid  = valid_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter: a latency-1 instance with a small peripheral model,
// plus a latency-3 instance whose model drives data only in cycle strobe+3.
module tb_csr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        r0_read, r0_write, r1_read, r1_write;
    logic [11:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ack, r0_valid, r1_ack, r1_valid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        csr_read, csr_write, busy, grant;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata = 32'h0;
    logic        csr_valid = 1'b0;

    logic        b_r0_read, b_r0_write, b_r1_read, b_r1_write;
    logic [11:0] b_r0_addr, b_r1_addr;
    logic [31:0] b_r0_wdata, b_r1_wdata;
    logic        b_r0_ack, b_r0_valid, b_r1_ack, b_r1_valid;
    logic [31:0] b_r0_rdata, b_r1_rdata;
    logic        b_csr_read, b_csr_write, b_busy, b_grant;
    logic [11:0] b_csr_addr;
    logic [31:0] b_csr_wdata;
    logic [31:0] b_csr_rdata;
    logic        b_csr_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_bus_arbiter #(.RESP_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_valid(r0_valid),
        .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_valid(r1_valid),
        .csr_read(csr_read), .csr_write(csr_write), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_valid(csr_valid), .busy(busy), .grant(grant)
    );

    csr_bus_arbiter #(.RESP_LATENCY(3), .STARVE_LIMIT(4)) dut_l3 (
        .clk(clk), .rst(rst),
        .r0_read(b_r0_read), .r0_write(b_r0_write), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata), .r0_valid(b_r0_valid),
        .r1_read(b_r1_read), .r1_write(b_r1_write), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata), .r1_valid(b_r1_valid),
        .csr_read(b_csr_read), .csr_write(b_csr_write), .csr_addr(b_csr_addr),
        .csr_wdata(b_csr_wdata), .csr_rdata(b_csr_rdata), .csr_valid(b_csr_valid),
        .busy(b_busy), .grant(b_grant)
    );

    // Peripheral model, latency 1: 0xFC0 reads 0xA, 0xBC3 is a scratch register,
    // everything else is unclaimed and drives junk data with valid low.
    logic [31:0] scratch = 32'h1234_5678;
    always @(posedge clk) begin
        if (csr_read || csr_write) begin
            case (csr_addr)
                12'hFC0: begin
                    csr_valid <= 1'b1;
                    csr_rdata <= 32'h0000_000A;
                end
                12'hBC3: begin
                    csr_valid <= 1'b1;
                    csr_rdata <= scratch;
                    if (csr_write) scratch <= csr_wdata;
                end
                default: begin
                    csr_valid <= 1'b0;
                    csr_rdata <= {20'hBAD00, csr_addr};
                end
            endcase
        end else begin
            csr_valid <= 1'b0;
            csr_rdata <= 32'h0;
        end
    end

    // Peripheral model, latency 3: data {0xCAFE0, addr} appears only in cycle strobe+3.
    logic        b_p1 = 1'b0, b_p2 = 1'b0, b_p3 = 1'b0;
    logic [11:0] b_a1 = '0, b_a2 = '0, b_a3 = '0;
    always @(posedge clk) begin
        b_p1 <= b_csr_read | b_csr_write;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
        b_a1 <= b_csr_addr;
        b_a2 <= b_a1;
        b_a3 <= b_a2;
    end
    assign b_csr_valid = b_p3;
    assign b_csr_rdata = b_p3 ? {20'hCAFE0, b_a3} : 32'h0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, r0_ack, r1_ack, csr_read, csr_write, r0_valid, r1_valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {busy, r0_ack, r1_ack, csr_read, csr_write, r0_valid, r1_valid});
        end
        checks++;
        if ({csr_addr, csr_wdata, r0_rdata, grant} !== 77'b0) begin
            failures++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h grant %b expected zeros",
                     csr_addr, csr_wdata, r0_rdata, grant);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy %b/%b expected 0/0", busy, b_busy);
        end
    endtask

    task automatic test_single_read();
        int strobes = 0, acks = 0, s_cyc = -1, a_cyc = -1;
        r0_addr = 12'hFC0;
        r0_read = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (csr_read || csr_write) begin
                strobes++;
                s_cyc = n;
                checks++;
                if (csr_addr !== 12'hFC0 || csr_write !== 1'b0) begin
                    failures++;
                    $display("FAIL read_strobe: addr %h write %b expected fc0 0", csr_addr, csr_write);
                end
            end
            if (r0_ack) begin
                acks++;
                a_cyc = n;
                r0_read = 1'b0;
                checks++;
                if (r0_rdata !== 32'h0000_000A || r0_valid !== 1'b1 || r1_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL read_resp: rdata %h valid %b r1_ack %b expected 0000000a 1 0",
                             r0_rdata, r0_valid, r1_ack);
                end
            end
        end
        checks++;
        if (strobes != 1 || acks != 1) begin
            failures++;
            $display("FAIL read_counts: strobes %0d acks %0d expected 1 1", strobes, acks);
        end
        checks++;
        if (a_cyc - s_cyc != 2) begin
            failures++;
            $display("FAIL read_latency: ack-strobe %0d expected 2", a_cyc - s_cyc);
        end
    endtask

    task automatic test_unmapped_write();
        int strobes = 0, acks = 0;
        r1_addr  = 12'h123;
        r1_wdata = 32'hDEAD_BEEF;
        r1_write = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (csr_read || csr_write) begin
                strobes++;
                checks++;
                if (csr_write !== 1'b1 || csr_read !== 1'b0 || csr_wdata !== 32'hDEAD_BEEF ||
                    csr_addr !== 12'h123) begin
                    failures++;
                    $display("FAIL write_strobe: rd %b wr %b addr %h wdata %h expected 0 1 123 deadbeef",
                             csr_read, csr_write, csr_addr, csr_wdata);
                end
            end
            if (r1_ack) begin
                acks++;
                r1_write = 1'b0;
                checks++;
                if (r1_valid !== 1'b0 || r1_rdata !== 32'h0 || grant !== 1'b1) begin
                    failures++;
                    $display("FAIL write_resp: valid %b rdata %h grant %b expected 0 0 1",
                             r1_valid, r1_rdata, grant);
                end
            end
            if (r0_ack) acks += 100;
        end
        checks++;
        if (strobes != 1 || acks != 1) begin
            failures++;
            $display("FAIL write_counts: strobes %0d acks %0d expected 1 1", strobes, acks);
        end
    endtask

    task automatic test_rmw();
        int strobes = 0, acks = 0;
        r0_addr  = 12'hBC3;
        r0_wdata = 32'h0000_0055;
        r0_read  = 1'b1;
        r0_write = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (csr_read || csr_write) begin
                strobes++;
                checks++;
                if (csr_read !== 1'b1 || csr_write !== 1'b1 || csr_wdata !== 32'h55) begin
                    failures++;
                    $display("FAIL rmw_strobe: rd %b wr %b wdata %h expected 1 1 00000055",
                             csr_read, csr_write, csr_wdata);
                end
            end
            if (r0_ack) begin
                acks++;
                r0_read  = 1'b0;
                r0_write = 1'b0;
                checks++;
                if (r0_rdata !== 32'h1234_5678 || r0_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rmw_old_value: rdata %h valid %b expected 12345678 1", r0_rdata, r0_valid);
                end
            end
        end
        checks++;
        if (strobes != 1 || acks != 1) begin
            failures++;
            $display("FAIL rmw_counts: strobes %0d acks %0d expected 1 1", strobes, acks);
        end
        acks = 0;
        r0_read = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (r0_ack) begin
                acks++;
                r0_read = 1'b0;
                checks++;
                if (r0_rdata !== 32'h0000_0055) begin
                    failures++;
                    $display("FAIL rmw_new_value: rdata %h expected 00000055", r0_rdata);
                end
            end
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL rmw_readback_ack: acks %0d expected 1", acks);
        end
    endtask

    task automatic test_contention();
        logic exp_q[$];
        logic exp_g, got_g;
        int   overlaps = 0, last_ack = -1;
        for (int i = 0; i < 10; i++) exp_q.push_back(i == 4 || i == 9);
        r0_addr = 12'hFC0;
        r1_addr = 12'hBC3;
        r0_read = 1'b1;
        r1_read = 1'b1;
        for (int n = 1; n <= 80 && exp_q.size() > 0; n++) begin
            tick();
            if (r0_ack && r1_ack) overlaps++;
            if (r0_ack || r1_ack) begin
                got_g = r1_ack;
                exp_g = exp_q.pop_front();
                checks++;
                if (got_g !== exp_g || grant !== exp_g) begin
                    failures++;
                    $display("FAIL contention_grant: ack from %0d grant %b expected %0d (remaining %0d)",
                             got_g, grant, exp_g, exp_q.size());
                end
                if (last_ack >= 0) begin
                    checks++;
                    if (n - last_ack != 4) begin
                        failures++;
                        $display("FAIL contention_spacing: gap %0d expected 4", n - last_ack);
                    end
                end
                last_ack = n;
            end
        end
        r0_read = 1'b0;
        r1_read = 1'b0;
        checks++;
        if (exp_q.size() != 0 || overlaps != 0) begin
            failures++;
            $display("FAIL contention_done: pending %0d overlaps %0d expected 0 0", exp_q.size(), overlaps);
        end
        tick();
        tick();
    endtask

    task automatic test_latency_sweep();
        int strobes = 0, s_cyc = -1, a_cyc = -1, addr_bad = 0, busy_bad = 0;
        b_r0_addr = 12'h7A5;
        b_r0_read = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (b_csr_read) begin
                strobes++;
                s_cyc = n;
            end
            if (s_cyc >= 0 && a_cyc < 0) begin
                if (b_csr_addr !== 12'h7A5) addr_bad++;
                if (b_busy !== 1'b1) busy_bad++;
            end
            if (b_r0_ack) begin
                a_cyc = n;
                b_r0_read = 1'b0;
                checks++;
                if (b_r0_rdata !== 32'hCAFE_07A5 || b_r0_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL lat3_data: rdata %h valid %b expected cafe07a5 1", b_r0_rdata, b_r0_valid);
                end
            end
        end
        checks++;
        if (strobes != 1 || a_cyc - s_cyc != 4) begin
            failures++;
            $display("FAIL lat3_timing: strobes %0d ack-strobe %0d expected 1 4", strobes, a_cyc - s_cyc);
        end
        checks++;
        if (addr_bad != 0 || busy_bad != 0) begin
            failures++;
            $display("FAIL lat3_stable: addr_bad %0d busy_bad %0d expected 0 0", addr_bad, busy_bad);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        bit seen = 0;
        r0_addr = 12'hFC0;
        r0_read = 1'b1;
        for (int n = 1; n <= 6 && !seen; n++) begin
            tick();
            if (csr_read) seen = 1;
        end
        tick();
        checks++;
        if (!seen || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup: strobe_seen %0d busy %b expected 1 1", seen, busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, csr_read, csr_write, r0_ack, r1_ack} !== 5'b0 || csr_addr !== 12'h0) begin
            failures++;
            $display("FAIL reset_mid_async: ctrl %b addr %h expected 00000 000",
                     {busy, csr_read, csr_write, r0_ack, r1_ack}, csr_addr);
        end
        r0_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (r0_ack || r1_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL reset_mid_no_ack: acks %0d expected 0", acks);
        end
        r0_read = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (r0_ack) begin
                acks++;
                r0_read = 1'b0;
                checks++;
                if (r0_rdata !== 32'h0000_000A || r0_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_mid_recover: rdata %h valid %b expected 0000000a 1", r0_rdata, r0_valid);
                end
            end
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL reset_mid_recover_ack: acks %0d expected 1", acks);
        end
    endtask

    initial begin
        rst = 1'b1;
        r0_read = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_read = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        b_r0_read = 1'b0; b_r0_write = 1'b0; b_r0_addr = '0; b_r0_wdata = '0;
        b_r1_read = 1'b0; b_r1_write = 1'b0; b_r1_addr = '0; b_r1_wdata = '0;
        test_reset();
        test_single_read();
        test_unmapped_write();
        test_rmw();
        test_contention();
        test_latency_sweep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
